// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. It accepts a byte stream over a
// valid/ready handshake. The first byte of a load is a length header N, giving
// the number of words. The next 4*N bytes are assembled big-endian into 32-bit
// words. Those words are written to consecutive instruction-memory addresses,
// starting at 0. The CPU is held in reset until the image is complete.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   After the last word, one further byte is expected. It must equal the XOR
//   of the header byte and all payload bytes. A mismatch rejects the load.
//   The words have already been written by then; a rejected load only keeps
//   the CPU in reset.
//
// Parameters:
//   ADDR_W     instruction-memory word-address width
//   MAX_WORDS  largest legal header value (must be <= 2**ADDR_W)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse that begins a load (idle/done/error only)
//   in_valid     in_data carries a byte
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (state-decoded only)
//   imem_we      one-cycle write strobe per assembled word
//   imem_addr    word address of the current write (held between writes)
//   imem_wdata   assembled word (held between writes)
//   word_count   words written so far in the current load
//   cpu_rst_n    CPU reset; high only once the image is accepted
//   done         image loaded and accepted
//   error        load rejected
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 5,
  parameter int MAX_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane;
  logic [23:0]       shift;     // bytes 0..2 of the word being assembled
  logic [CNT_W-1:0]  n_words;
  logic              accept;
  logic              load;
  logic              last_lane;
  logic              last_word;
  logic              hdr_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = in_valid && in_ready;
  // A load may restart only from a resting state. Start is ignored mid-load.
  assign load      = start && (state_q == S_IDLE || state_q == S_DONE ||
                               state_q == S_ERR);
  assign last_lane = (lane == 2'd3);
  assign last_word = ((word_count + CNT_W'(1)) == n_words);
  assign hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= MAX_WORDS);

  // CPU release follows the registered done flag. Both rise together.
  assign cpu_rst_n = done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is assigned a default first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (accept) state_d = hdr_ok ? S_DATA : S_ERR;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept && last_lane && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_d = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        if (start) state_d = S_LEN;
      end
      S_ERR: begin
        if (start) state_d = S_LEN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: word assembly, write strobe, counters, status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= 2'd0;
      shift      <= 24'd0;
      n_words    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      // The status flags follow the resting state one cycle later. So done
      // rises the cycle after the final write strobe. Start clears the flags
      // on the same edge that leaves the resting state.
      done    <= (state_q == S_DONE) && !start;
      error   <= (state_q == S_ERR)  && !start;

      if (load) begin
        lane       <= 2'd0;
        shift      <= 24'd0;
        imem_addr  <= '0;
        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end else if (accept) begin
        if (state_q == S_LEN) begin
          // Out-of-range headers are truncated here, but they go to ERR anyway.
          n_words <= CNT_W'(in_data);
`ifdef LOADER_CHECKSUM_EN
          csum    <= csum ^ in_data;
`endif
        end else if (state_q == S_DATA) begin
          lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          if (last_lane) begin
            imem_we    <= 1'b1;
            imem_wdata <= {shift, in_data};
            imem_addr  <= word_count[ADDR_W-1:0];  // wraps modulo 2**ADDR_W
            word_count <= word_count + CNT_W'(1);
          end else begin
            shift <= {shift[15:0], in_data};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboard bench for imem_loader. Each load pushes its expected writes
// (address, word, running count) and its expected outcome (done or error)
// into queues. A monitor pops one entry on every write strobe and on every
// rising edge of done or error, then compares it with the DUT outputs.
// Expected words come straight from the byte stream: the big-endian
// concatenation of each group of four bytes.
// When LOADER_CHECKSUM_EN is defined, the bench also sends the checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W    = 5;
  localparam int MAX_WORDS = 32;
  localparam int RES_DONE  = 1;
  localparam int RES_ERR   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_rst_n;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          count;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_wr[$];
  int          exp_res[$];
  logic [7:0]  payload [0:127];
  int          cycle = 0;
  int          last_we_cycle = 0;
  logic        prev_done = 1'b0;
  logic        prev_error = 1'b0;
  wr_t         mw;
  int          mr;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT events against the scoreboard queues
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done  = 1'b0;
      prev_error = 1'b0;
    end else begin
      if (imem_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mw = exp_wr.pop_front();
          check("write_addr",  imem_addr,  mw.addr);
          check("write_data",  imem_wdata, mw.data);
          check("write_count", word_count, mw.count);
        end
        last_we_cycle = cycle;
      end
      if (done && !prev_done) begin
        if (exp_res.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mr = exp_res.pop_front();
          check("result_done", RES_DONE, mr);
        end
        check("cpu_release", cpu_rst_n, 1);
`ifndef LOADER_CHECKSUM_EN
        check("done_latency", cycle, last_we_cycle + 1);
`endif
      end
      if (error && !prev_error) begin
        if (exp_res.size() == 0) check("unexpected_error", 1, 0);
        else begin
          mr = exp_res.pop_front();
          check("result_error", RES_ERR, mr);
        end
        check("cpu_held", cpu_rst_n, 0);
      end
      prev_done  = done;
      prev_error = error;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each is entered and left at a falling edge
  // ---------------------------------------------------------------------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_imem_we"},    imem_we,    0);
    check({tag, "_imem_addr"},  imem_addr,  0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_word_count"}, word_count, 0);
    check({tag, "_cpu_rst_n"},  cpu_rst_n,  0);
    check({tag, "_done"},       done,       0);
    check({tag, "_error"},      error,      0);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", in_ready, 1);
    check("error_after_start", error, 0);
    check("done_after_start",  done, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap,
                           input bit st);
    bit ok;
    repeat ($urandom_range(max_gap, 0)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input int budget);
    for (int i = 0; i < budget && exp_res.size() != 0; i++) @(negedge clk);
    check("result_timeout", exp_res.size(), 0);
  endtask

  // One complete load. The bytes come from payload[0 .. 4n-1].
  task automatic do_load(input int n, input int max_gap, input bit corrupt,
                         input bit mid_start);
    logic [7:0] sum;
    wr_t        w;
    int         t0;
    sum = 8'(n);
    if (n == 0 || n > MAX_WORDS) exp_res.push_back(RES_ERR);
    else begin
      for (int k = 0; k < n; k++) begin
        w.addr  = k % (1 << ADDR_W);
        w.data  = {payload[4*k], payload[4*k+1], payload[4*k+2], payload[4*k+3]};
        w.count = k + 1;
        exp_wr.push_back(w);
      end
`ifdef LOADER_CHECKSUM_EN
      exp_res.push_back(corrupt ? RES_ERR : RES_DONE);
`else
      exp_res.push_back(RES_DONE);
`endif
    end
    start_pulse();
    send_byte(8'(n), max_gap, 1'b0);
    t0 = cycle;
    if (n >= 1 && n <= MAX_WORDS) begin
      for (int i = 0; i < 4 * n; i++) begin
        sum ^= payload[i];
        send_byte(payload[i], max_gap, mid_start && i == 1);
      end
      if (max_gap == 0) check("throughput", cycle - t0, 4 * n);
`ifdef LOADER_CHECKSUM_EN
      send_byte(corrupt ? (sum ^ 8'h03) : sum, max_gap, 1'b0);
`endif
    end
    wait_result(20);
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) payload[i] = 8'($urandom);
  endtask

  // Holds in_valid high while the loader is not ready. None of these bytes
  // may be consumed.
  task automatic junk_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(255, 1));
      check("ready_low_resting", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    junk_bytes(3);

    // Reference two-word image, streamed back to back.
    payload[0] = 8'h20; payload[1] = 8'h02; payload[2] = 8'h00; payload[3] = 8'h05;
    payload[4] = 8'h8C; payload[5] = 8'h43; payload[6] = 8'h00; payload[7] = 8'h04;
    do_load(2, 0, 1'b0, 1'b0);
    check("ref_done",      done,       1);
    check("ref_cpu_rst_n", cpu_rst_n,  1);
    check("ref_count",     word_count, 2);
    junk_bytes(3);

    // Illegal headers.
    do_load(0, 0, 1'b0, 1'b0);
    check("hdr0_error", error, 1);
    check("hdr0_cpu",   cpu_rst_n, 0);
    junk_bytes(2);
    do_load(MAX_WORDS + 1, 0, 1'b0, 1'b0);
    check("hdr33_error", error, 1);
    check("hdr33_cpu",   cpu_rst_n, 0);

    // Single word with random gaps.
    for (int r = 0; r < 3; r++) begin
      fill_random(4);
      do_load(1, 3, 1'b0, 1'b0);
    end

    // Reset in the middle of a load.
    fill_random(8);
    start_pulse();
    send_byte(8'd2, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(payload[i], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(8);
    do_load(2, 1, 1'b0, 1'b0);
    check("post_reset_count", word_count, 2);

    // Start pulse during the data phase is ignored.
    fill_random(12);
    do_load(3, 0, 1'b0, 1'b1);
    check("mid_start_count", word_count, 3);

    // Full-size image and random sizes.
    fill_random(4 * MAX_WORDS);
    do_load(MAX_WORDS, 0, 1'b0, 1'b0);
    check("full_count", word_count, MAX_WORDS);
    for (int r = 0; r < 4; r++) begin
      fill_random(4 * MAX_WORDS);
      do_load($urandom_range(MAX_WORDS - 1, 1), 2, 1'b0, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
    do_load(1, 0, 1'b0, 1'b0);
    check("csum_good_done", done, 1);
    do_load(1, 0, 1'b1, 1'b0);
    check("csum_bad_error", error, 1);
    check("csum_bad_cpu",   cpu_rst_n, 0);
`endif

    repeat (3) @(negedge clk);
    check("leftover_writes",  exp_wr.size(),  0);
    check("leftover_results", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
